// File: rtl/imem_dmem_port_arbiter.sv
// Shares one memory port between instruction fetch and MEM-stage data access.
// Data wins ties, a request is held until mem_ready, and a flushed fetch is drained silently.
module imem_dmem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_valid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_done,
    output logic [DATA_W-1:0]     d_rdata,
    input  logic                  flush,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  stall_fetch,
    output logic                  stall_mem
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FETCH      = 2'd1,
        DATA       = 2'd2,
        FETCH_KILL = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   grant_d, grant_f;

    always_comb begin
        state_d = state_q;
        grant_d = 1'b0;
        grant_f = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    grant_d = 1'b1;
                    state_d = DATA;
                end else if (if_req && !flush) begin
                    grant_f = 1'b1;
                    state_d = FETCH;
                end
            end
            // mem_ready wins over flush: the fetch is finished, only its strobe is suppressed
            FETCH: begin
                if (mem_ready)  state_d = IDLE;
                else if (flush) state_d = FETCH_KILL;
            end
            DATA:       if (mem_ready) state_d = IDLE;
            FETCH_KILL: if (mem_ready) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q <= state_d;
            if (grant_d) begin
                mem_we    <= d_we;
                mem_wstrb <= d_wstrb;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (grant_f) begin
                mem_we    <= 1'b0;
                mem_wstrb <= '0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end
        end
    end

    assign mem_req     = (state_q != IDLE);
    assign if_valid    = (state_q == FETCH) && mem_ready && !flush;
    assign d_done      = (state_q == DATA) && mem_ready;
    assign if_rdata    = mem_rdata;
    assign d_rdata     = mem_rdata;
    assign stall_fetch = if_req & ~if_valid;
    assign stall_mem   = d_req & ~d_done;

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Directed bench for the memory port arbiter; completions are matched against a scoreboard queue.
module tb_imem_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we, flush, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_wstrb;
    logic        if_valid, d_done, mem_req, mem_we, stall_fetch, stall_mem;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    imem_dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_fetch(stall_fetch), .stall_mem(stall_mem)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_done(input logic is_data, input logic [31:0] rdata);
        exp_t e;
        e.is_data = is_data;
        e.rdata   = rdata;
        sb.push_back(e);
    endtask

    // Wait for the mid-cycle sample point and retire any completion strobe against the scoreboard.
    task automatic settle();
        exp_t e;
        @(negedge clk);
        if (if_valid || d_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {30'd0, d_done, if_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("strobe_kind", {30'd0, d_done, if_valid}, e.is_data ? 32'd2 : 32'd1);
                chk("strobe_rdata", e.is_data ? d_rdata : if_rdata, e.rdata);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; flush = 1'b0;
        mem_ready = 1'b0; if_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_rdata = '0;

        // reset state
        settle();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_strobes", {30'd0, d_done, if_valid}, 32'd0);
        adv();
        rst_n = 1'b1;
        adv();

        // single fetch, zero wait
        if_req = 1'b1; if_addr = 32'h100;
        settle();
        chk("f1_stall_c", 32'(stall_fetch), 32'd1);
        chk("f1_req_c", 32'(mem_req), 32'd0);
        adv();
        mem_ready = 1'b1; mem_rdata = 32'h00500093;
        expect_done(1'b0, 32'h00500093);
        settle();
        chk("f1_req", 32'(mem_req), 32'd1);
        chk("f1_addr", mem_addr, 32'h100);
        chk("f1_we", 32'(mem_we), 32'd0);
        chk("f1_valid", 32'(if_valid), 32'd1);
        chk("f1_stall_c1", 32'(stall_fetch), 32'd0);
        adv();
        if_req = 1'b0; mem_ready = 1'b0;
        settle();
        chk("f1_idle", 32'(mem_req), 32'd0);
        adv();

        // tie: data wins, store with two wait states, then the fetch
        if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
        settle();
        chk("tie_stall_f", 32'(stall_fetch), 32'd1);
        chk("tie_stall_m", 32'(stall_mem), 32'd1);
        adv();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                mem_ready = 1'b1; mem_rdata = 32'h0;
                expect_done(1'b1, 32'h0);
            end
            settle();
            chk("tie_we", 32'(mem_we), 32'd1);
            chk("tie_addr", mem_addr, 32'h2000);
            chk("tie_wdata", mem_wdata, 32'hDEADBEEF);
            chk("tie_wstrb", 32'(mem_wstrb), 32'hF);
            chk("tie_done", 32'(d_done), (i == 2) ? 32'd1 : 32'd0);
            chk("tie_stall_f_hold", 32'(stall_fetch), 32'd1);
            adv();
        end
        d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        settle();
        chk("tie_gap_req", 32'(mem_req), 32'd0);
        chk("tie_gap_stall", 32'(stall_fetch), 32'd1);
        adv();
        mem_ready = 1'b1; mem_rdata = 32'h00000013;
        expect_done(1'b0, 32'h00000013);
        settle();
        chk("tie_f_addr", mem_addr, 32'h104);
        chk("tie_f_we", 32'(mem_we), 32'd0);
        chk("tie_f_wdata", mem_wdata, 32'd0);
        chk("tie_f_wstrb", 32'(mem_wstrb), 32'd0);
        adv();
        if_req = 1'b0; mem_ready = 1'b0;
        adv();

        // load with four wait states
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2004; d_wstrb = 4'h0;
        settle();
        chk("ld_stall_c", 32'(stall_mem), 32'd1);
        adv();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                mem_ready = 1'b1; mem_rdata = 32'h12345678;
                expect_done(1'b1, 32'h12345678);
            end
            settle();
            chk("ld_req", 32'(mem_req), 32'd1);
            chk("ld_addr", mem_addr, 32'h2004);
            chk("ld_stall", 32'(stall_mem), (i == 4) ? 32'd0 : 32'd1);
            adv();
        end
        d_req = 1'b0; mem_ready = 1'b0;
        adv();

        // flush on first FETCH cycle, fetch drained in FETCH_KILL
        if_req = 1'b1; if_addr = 32'h200;
        adv();
        flush = 1'b1;
        settle();
        chk("fk_req", 32'(mem_req), 32'd1);
        chk("fk_valid0", 32'(if_valid), 32'd0);
        adv();
        flush = 1'b0; if_addr = 32'h300;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 0);
            if (i == 2) begin
                mem_ready = 1'b1; mem_rdata = 32'hBADBAD00;
            end
            settle();
            chk("fk_hold_req", 32'(mem_req), 32'd1);
            chk("fk_hold_addr", mem_addr, 32'h200);
            chk("fk_no_valid", 32'(if_valid), 32'd0);
            chk("fk_stall", 32'(stall_fetch), 32'd1);
            adv();
        end
        flush = 1'b0; mem_ready = 1'b0;
        settle();
        chk("fk_gap", 32'(mem_req), 32'd0);
        adv();
        mem_ready = 1'b1; mem_rdata = 32'hAAAA0001;
        expect_done(1'b0, 32'hAAAA0001);
        settle();
        chk("fk_new_addr", mem_addr, 32'h300);
        adv();
        if_req = 1'b0; mem_ready = 1'b0;
        adv();

        // flush coincident with mem_ready
        if_req = 1'b1; if_addr = 32'h400;
        adv();
        flush = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hCAFE0000;
        settle();
        chk("fr_valid", 32'(if_valid), 32'd0);
        adv();
        flush = 1'b1; mem_ready = 1'b1;
        settle();
        chk("fr_idle", 32'(mem_req), 32'd0);
        adv();
        // flush blocks a fetch grant in IDLE; mem_ready in IDLE is ignored
        settle();
        chk("fr_no_grant", 32'(mem_req), 32'd0);
        adv();
        if_req = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        adv();

        // asynchronous reset in the middle of a data access
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
        adv();
        settle();
        chk("rs_busy", 32'(mem_req), 32'd1);
        adv();
        mem_ready = 1'b1; rst_n = 1'b0;
        #1;
        chk("rs_req_async", 32'(mem_req), 32'd0);
        chk("rs_done_async", 32'(d_done), 32'd0);
        settle();
        adv();
        d_req = 1'b0; mem_ready = 1'b0; rst_n = 1'b1;
        settle();
        chk("rs_after_req", 32'(mem_req), 32'd0);
        chk("rs_after_addr", mem_addr, 32'd0);
        adv();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3008; d_wdata = 32'h55; d_wstrb = 4'h3;
        adv();
        mem_ready = 1'b1; mem_rdata = 32'h0;
        expect_done(1'b1, 32'h0);
        settle();
        chk("rs_new_addr", mem_addr, 32'h3008);
        chk("rs_new_wstrb", 32'(mem_wstrb), 32'h3);
        chk("rs_new_we", 32'(mem_we), 32'd1);
        adv();
        d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        settle();
        adv();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_dmem_port_arbiter.md
Name: imem_dmem_port_arbiter

Overview:
- Sequences the single unified memory port of the pipelined RV32 core. It is shared between instruction fetch (IF) and the data access of the MEM stage.
- Grants one requester at a time, with data priority, and holds the memory request until mem_ready.
- Returns read data with a one-cycle-valid completion strobe.
- Produces the structural-hazard stall signals that the pipeline control ORs with the load-use stall.
- Cancels an in-flight fetch on branch flush.

Parameters:
- ADDR_W, 32, width of address buses.
- DATA_W, 32, width of data buses. wstrb width is DATA_W/8.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  ADDR_W  fetch address (PC).
- if_valid  out  1  fetch complete this cycle; if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction (mem_rdata pass-through).
- d_req  in  1  data request from MEM stage; held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_wstrb  in  DATA_W/8  byte enables for store.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_done  out  1  data access complete this cycle.
- d_rdata  out  DATA_W  load data (mem_rdata pass-through).
- flush  in  1  branch/jump taken; kill the pending or in-flight fetch.
- mem_req  out  1  memory transaction active.
- mem_we  out  1  write enable.
- mem_wstrb  out  DATA_W/8  byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ready=1.
- mem_ready  in  1  memory completes the current transaction this cycle.
- stall_fetch  out  1  hold PC and IF/ID.
- stall_mem  out  1  hold the whole pipeline (MEM stage blocked).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata = 0.
  - if_valid, d_done = 0.
  - Reset mid-transaction abandons it; mem_req drops immediately, no completion strobe.
- FSM states: IDLE, FETCH, DATA, FETCH_KILL.
- IDLE:
  - If d_req: latch d_addr/d_we/d_wstrb/d_wdata into the mem_* registers and go to DATA.
  - Else if if_req and !flush: latch if_addr with mem_we=0, mem_wstrb=0, mem_wdata=0, and go to FETCH.
  - Else stay in IDLE.
  - Data always wins a same-cycle tie.
- mem_req = (state != IDLE). mem_* registers stay stable for the whole transaction.
- DATA:
  - On mem_ready: d_done=1 (combinational, same cycle), then go to IDLE.
  - Otherwise stay in DATA; wait states are unbounded.
- FETCH:
  - On mem_ready and !flush: if_valid=1 (same cycle), then go to IDLE.
  - On flush without mem_ready: go to FETCH_KILL.
  - On mem_ready together with flush: if_valid=0, then go to IDLE.
- FETCH_KILL:
  - Keep mem_req until mem_ready; discard the data with no if_valid; then go to IDLE.
  - flush here has no further effect.
- mem_ready is ignored in IDLE.
- Requesters advance on the edge that ends the done/valid cycle. In the following IDLE cycle the req inputs refer to a new transaction, so there is no double grant.
- Latency:
  - Grant in the request cycle c (when IDLE); mem_req high from c+1.
  - Completion in the cycle mem_ready is seen; minimum 2 cycles request-to-done.
  - One IDLE cycle between consecutive transactions.
- Stalls (combinational):
  - stall_fetch = if_req & ~if_valid.
  - stall_mem = d_req & ~d_done.
  - While stall_mem=1 the fetch stage is also held by pipeline control; that is outside this block.
- if_rdata and d_rdata = mem_rdata unconditionally; they are meaningful only with their strobe.
- A request arriving while another is in flight waits in IDLE arbitration. No queuing beyond the held req line.

Test Plan:
- Single fetch, zero wait: if_req=1, if_addr=0x100, mem_ready=1 on the first mem_req cycle, mem_rdata=0x00500093 -> mem_req at c+1 with mem_addr=0x100, mem_we=0; if_valid=1 and if_rdata=0x00500093 at c+1; stall_fetch=1 at c only.
- Tie: if_req=1 and d_req=1 (d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=0xF) in IDLE, mem_ready after 2 wait cycles -> data granted first; mem_we=1 for 3 cycles; d_done at the 3rd; fetch granted after the IDLE cycle; stall_fetch high throughout.
- Load with waits: d_req load at 0x2004, mem_ready low 4 cycles then high with 0x12345678 -> mem_req high 5 cycles, address stable; d_done=1 and d_rdata=0x12345678 on the 5th; stall_mem=1 for the 5 preceding cycles.
- Flush in flight: fetch granted, flush pulse on the first FETCH cycle, mem_ready 3 cycles later -> state FETCH_KILL; mem_req held until mem_ready; if_valid never asserted; next fetch granted only after the IDLE cycle.
- Flush coincident with mem_ready in FETCH -> if_valid=0; state IDLE next cycle.
- Reset mid-transaction: rst_n low during DATA with wait states -> mem_req=0 and d_done=0 immediately (asynchronous); after release state=IDLE and a new d_req is granted normally.
